// File: rtl/irrigation_scheduler.sv
// Purpose : one sequenced FSM time-sharing the tank valve/pump between fill, splinker, dripper and fertiliser.
// Latency : every decision and every output lands 1 clock after the input or tick that causes it.
// Backpressure: none; requesters are level-held switches, grants are released by the tick-based counter.
// Option  : SCHED_ROUND_ROBIN_EN - alternate splinker/dripper grants when both request from IDLE.
module irrigation_scheduler #(
    parameter int CNT_W       = 4,
    parameter int HOLD_TICKS  = 2,
    parameter int WATER_TICKS = 7,
    parameter int CLEAN_TICKS = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       input_error,
    input  logic       critical_tank_level,
    input  logic       full_tank,
    input  logic       splinker_req,
    input  logic       dripper_req,
    input  logic       fertilise_req,
    output logic [2:0] state,
    output logic       filling,
    output logic       splinker,
    output logic       dripper,
    output logic       fertilising,
    output logic       cleaning,
    output logic       busy
);

    // Phase codes; these are also the display code on the state output.
    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_FILL   = 3'b001;
    localparam logic [2:0] ST_SPLINK = 3'b010;
    localparam logic [2:0] ST_DRIP   = 3'b011;
    localparam logic [2:0] ST_FERT   = 3'b100;
    localparam logic [2:0] ST_CLEAN  = 3'b101;
    localparam logic [2:0] ST_ERROR  = 3'b110;

    // Counter thresholds, sized to the counter so comparisons stay width-matched.
    localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] WATER_LIM = CNT_W'(WATER_TICKS);
    localparam logic [CNT_W-1:0] CLEAN_LIM = CNT_W'(CLEAN_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             filling_q, filling_d;
    logic             splinker_q, splinker_d;
    logic             dripper_q, dripper_d;
    logic             fertilising_q, fertilising_d;
    logic             cleaning_q, cleaning_d;
    logic             busy_q, busy_d;

    // Splinker-vs-dripper choice from IDLE when both switches are on.
    logic             pick_drip;

`ifdef SCHED_ROUND_ROBIN_EN
    // Last watering valve served: 0 = splinker, 1 = dripper.
    logic             last_water_q, last_water_d;

    // Give the contested grant to whichever valve was not served last.
    always_comb begin
        pick_drip = ~last_water_q;
    end

    // Remember the valve on every fresh watering grant.
    always_comb begin
        last_water_d = last_water_q;
        if (state_d != state_q) begin
            if (state_d == ST_SPLINK) begin
                last_water_d = 1'b0;
            end else if (state_d == ST_DRIP) begin
                last_water_d = 1'b1;
            end
        end
    end

    // Round-robin history register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_water_q <= 1'b0;
        end else begin
            last_water_q <= last_water_d;
        end
    end
`else
    // Fixed priority: splinker always beats dripper.
    always_comb begin
        pick_drip = 1'b0;
    end
`endif

    // Next-phase selection; input_error outranks everything, including an active flush.
    always_comb begin
        state_d = state_q;
        if (input_error) begin
            state_d = ST_ERROR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (critical_tank_level) begin
                        state_d = ST_FILL;
                    end else if (fertilise_req) begin
                        state_d = ST_FERT;
                    end else if (splinker_req && dripper_req) begin
                        state_d = pick_drip ? ST_DRIP : ST_SPLINK;
                    end else if (splinker_req) begin
                        state_d = ST_SPLINK;
                    end else if (dripper_req) begin
                        state_d = ST_DRIP;
                    end
                end
                ST_FILL: begin
                    // full_tank wins even if critical is also (illegally) high.
                    if (full_tank) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SPLINK: begin
                    if (critical_tank_level) begin
                        state_d = ST_FILL;
                    end else if ((!splinker_req && (cnt_q >= HOLD_LIM)) || (cnt_q == WATER_LIM)) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DRIP: begin
                    if (critical_tank_level) begin
                        state_d = ST_FILL;
                    end else if ((!dripper_req && (cnt_q >= HOLD_LIM)) || (cnt_q == WATER_LIM)) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FERT: begin
                    if (!fertilise_req || critical_tank_level) begin
                        state_d = ST_CLEAN;
                    end
                end
                ST_CLEAN: begin
                    // Flush always completes; a low tank is handled from IDLE afterwards.
                    if (cnt_q == CLEAN_LIM) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ERROR: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Phase tick counter: restarts on a phase change (dropping a coincident tick), saturates at the top.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // One-hot valve decode of the next phase, so outputs register alongside the state.
    always_comb begin
        filling_d     = (state_d == ST_FILL);
        splinker_d    = (state_d == ST_SPLINK);
        dripper_d     = (state_d == ST_DRIP);
        fertilising_d = (state_d == ST_FERT);
        cleaning_d    = (state_d == ST_CLEAN);
        busy_d        = (state_d != ST_IDLE);
    end

    // Phase, counter and output registers; reset aborts any phase at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            filling_q     <= 1'b0;
            splinker_q    <= 1'b0;
            dripper_q     <= 1'b0;
            fertilising_q <= 1'b0;
            cleaning_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            filling_q     <= filling_d;
            splinker_q    <= splinker_d;
            dripper_q     <= dripper_d;
            fertilising_q <= fertilising_d;
            cleaning_q    <= cleaning_d;
            busy_q        <= busy_d;
        end
    end

    assign state       = state_q;
    assign filling     = filling_q;
    assign splinker    = splinker_q;
    assign dripper     = dripper_q;
    assign fertilising = fertilising_q;
    assign cleaning    = cleaning_q;
    assign busy        = busy_q;

endmodule
